// File: rtl/control_cmd_dumprow_pkg.sv
// rtl/control_cmd_dumprow_pkg.sv - shared panel geometry, address-width helpers and dump-row state type
package control_cmd_dumprow_pkg;

    localparam int DEFAULT_BYTES_PER_PIXEL = 3;
    localparam int DEFAULT_PIXEL_HEIGHT    = 32;
    localparam int DEFAULT_PIXEL_WIDTH     = 64;

    typedef enum logic [2:0] {
        DR_IDLE,
        DR_HEADER,
        DR_WAIT,
        DR_EMIT,
        DR_DONE
    } dumprow_state_e;

    // Every address field keeps at least one bit so degenerate 1-wide panels still elaborate.
    function automatic int num_row_address_bits(input int height);
        return (height > 1) ? $clog2(height) : 1;
    endfunction

    function automatic int num_column_address_bits(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic int num_pixelcolorselect_bits(input int bytes_per_pixel);
        return (bytes_per_pixel > 1) ? $clog2(bytes_per_pixel) : 1;
    endfunction

endpackage

// File: rtl/control_cmd_dumprow_pixel_addr_counter.sv
// rtl/control_cmd_dumprow_pixel_addr_counter.sv - column/pixel down-counter with load, decrement and last flag
module pixel_addr_counter #(
    parameter int PIXEL_WIDTH     = 4,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int COL_BITS        = 2,
    parameter int PIX_BITS        = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic                dec,
    output logic [COL_BITS-1:0] column,
    output logic [PIX_BITS-1:0] pixel,
    output logic                last
);

    logic [COL_BITS-1:0] column_d, column_q;
    logic [PIX_BITS-1:0] pixel_d, pixel_q;

    assign last   = (column_q == '0) && (pixel_q == '0);
    assign column = column_q;
    assign pixel  = pixel_q;

    // Decrement is ignored at (0,0) so the address can never wrap.
    always_comb begin
        column_d = column_q;
        pixel_d  = pixel_q;
        if (load) begin
            column_d = COL_BITS'(PIXEL_WIDTH - 1);
            pixel_d  = PIX_BITS'(BYTES_PER_PIXEL - 1);
        end else if (dec && !last) begin
            if (pixel_q == '0) begin
                pixel_d  = PIX_BITS'(BYTES_PER_PIXEL - 1);
                column_d = column_q - 1'b1;
            end else begin
                pixel_d = pixel_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            column_q <= '0;
            pixel_q  <= '0;
        end else begin
            column_q <= column_d;
            pixel_q  <= pixel_d;
        end
    end

endmodule

// File: rtl/control_cmd_dumprow.sv
// rtl/control_cmd_dumprow.sv - streams a row-selector byte then every byte of one framebuffer row
module control_cmd_dumprow
    import control_cmd_dumprow_pkg::*;
#(
    parameter int BYTES_PER_PIXEL  = DEFAULT_BYTES_PER_PIXEL,
    parameter int PIXEL_HEIGHT     = DEFAULT_PIXEL_HEIGHT,
    parameter int PIXEL_WIDTH      = DEFAULT_PIXEL_WIDTH,
    parameter int RAM_READ_LATENCY = 1,
    parameter int _UNUSED          = 0,
    localparam int ROW_BITS = num_row_address_bits(PIXEL_HEIGHT),
    localparam int COL_BITS = num_column_address_bits(PIXEL_WIDTH),
    localparam int PIX_BITS = num_pixelcolorselect_bits(BYTES_PER_PIXEL)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ROW_BITS-1:0] start_row,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [ROW_BITS-1:0] row,
    output logic [COL_BITS-1:0] column,
    output logic [PIX_BITS-1:0] pixel,
    output logic                ram_read_enable,
    input  logic [7:0]          ram_data,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready
);

    dumprow_state_e      state_d, state_q;
    logic                busy_d, busy_q;
    logic                done_d, done_q;
    logic                rre_d, rre_q;
    logic                tx_valid_d, tx_valid_q;
    logic [7:0]          tx_data_d, tx_data_q;
    logic [ROW_BITS-1:0] row_d, row_q;
    logic [1:0]          wait_cnt_d, wait_cnt_q;
    logic                ctr_load, ctr_dec, ctr_last, accept;

    assign accept = tx_valid_q & tx_ready;

    pixel_addr_counter #(
        .PIXEL_WIDTH    (PIXEL_WIDTH),
        .BYTES_PER_PIXEL(BYTES_PER_PIXEL),
        .COL_BITS       (COL_BITS),
        .PIX_BITS       (PIX_BITS)
    ) u_addr (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (ctr_load),
        .dec    (ctr_dec),
        .column (column),
        .pixel  (pixel),
        .last   (ctr_last)
    );

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rre_d      = 1'b0;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        row_d      = row_q;
        wait_cnt_d = wait_cnt_q;
        ctr_load   = 1'b0;
        ctr_dec    = 1'b0;
        case (state_q)
            DR_IDLE: if (start) begin
                row_d      = start_row;
                ctr_load   = 1'b1;
                tx_data_d  = 8'(start_row);
                tx_valid_d = 1'b1;
                busy_d     = 1'b1;
                state_d    = DR_HEADER;
            end
            DR_HEADER: if (accept) begin
                tx_valid_d = 1'b0;
                rre_d      = 1'b1;
                wait_cnt_d = '0;
                state_d    = DR_WAIT;
            end
            // Counter is 0 in the strobe cycle; data is valid once it reaches the latency.
            DR_WAIT: if (wait_cnt_q == 2'(RAM_READ_LATENCY)) begin
                tx_data_d  = ram_data;
                tx_valid_d = 1'b1;
                state_d    = DR_EMIT;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
            DR_EMIT: if (accept) begin
                tx_valid_d = 1'b0;
                if (ctr_last) begin
                    done_d  = 1'b1;
                    state_d = DR_DONE;
                end else begin
                    ctr_dec    = 1'b1;
                    rre_d      = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = DR_WAIT;
                end
            end
            DR_DONE: begin
                busy_d  = 1'b0;
                state_d = DR_IDLE;
            end
            default: state_d = DR_IDLE;
        endcase
        if (abort && state_q != DR_IDLE) begin
            state_d    = DR_IDLE;
            tx_valid_d = 1'b0;
            rre_d      = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            ctr_dec    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= DR_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rre_q      <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            row_q      <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rre_q      <= rre_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            row_q      <= row_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign ram_read_enable = rre_q;
    assign tx_valid        = tx_valid_q;
    assign tx_data         = tx_data_q;
    assign row             = row_q;

endmodule
